// File: rtl/regfile_sb_pkg.sv
// Shared definitions for the scoreboarded register file: FSM encoding,
// default parameter values and the zero-word constant.
package regfile_sb_pkg;

    typedef enum logic {
        ST_CLEAR = 1'b0,
        ST_RUN   = 1'b1
    } rf_state_t;

    localparam int DEF_DATA_W  = 32;
    localparam int DEF_ADDR_W  = 5;
    localparam int DEF_NUM_RD  = 2;
    localparam bit DEF_ZERO_R0 = 1'b1;

    localparam logic [DEF_DATA_W-1:0] ZERO_WORD = '0;

endpackage : regfile_sb_pkg

// File: rtl/regfile_rdport.sv
// One combinational read port: enable gating, hard-wired zero register and
// write-port bypass with port 1 taking precedence over port 0.
module regfile_rdport
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter bit ZERO_R0 = DEF_ZERO_R0
) (
    input  logic              en_i,
    input  logic [ADDR_W-1:0] ra_i,
    input  logic [DATA_W-1:0] stored_i,
    input  logic              wr0_i,
    input  logic [ADDR_W-1:0] wa0_i,
    input  logic [DATA_W-1:0] wd0_i,
    input  logic              wr1_i,
    input  logic [ADDR_W-1:0] wa1_i,
    input  logic [DATA_W-1:0] wd1_i,
    output logic [DATA_W-1:0] rd_o
);

    logic is_zero_reg;
    logic hit0;
    logic hit1;

    assign is_zero_reg = ZERO_R0 && (ra_i == '0);
    // wrX_i already carries the commit qualification, so a hit means the
    // value being written this cycle is the one the array will hold next.
    assign hit0 = wr0_i && (wa0_i == ra_i);
    assign hit1 = wr1_i && (wa1_i == ra_i);

    always_comb begin
        rd_o = DATA_W'(ZERO_WORD);
        if (en_i && !is_zero_reg) begin
            if (hit1) begin
                rd_o = wd1_i;
            end else if (hit0) begin
                rd_o = wd0_i;
            end else begin
                rd_o = stored_i;
            end
        end
    end

endmodule : regfile_rdport

// File: rtl/regfile_sb.sv
// Register file with two write ports, NUM_RD bypassed read ports and a
// per-entry busy scoreboard; storage is zeroed by a one-entry-per-cycle sweep.
module regfile_sb
    import regfile_sb_pkg::*;
#(
    parameter int DATA_W  = DEF_DATA_W,
    parameter int ADDR_W  = DEF_ADDR_W,
    parameter int NUM_RD  = DEF_NUM_RD,
    parameter bit ZERO_R0 = DEF_ZERO_R0
) (
    input  logic                     cpu_clk_50M,
    input  logic                     cpu_rst_n,
    input  logic                     clr_req,
    output logic                     ready,
    input  logic                     we0,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [DATA_W-1:0]        wd0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd1,
    input  logic [NUM_RD-1:0]        re,
    input  logic [NUM_RD*ADDR_W-1:0] ra,
    output logic [NUM_RD*DATA_W-1:0] rd,
    output logic [NUM_RD-1:0]        rd_busy,
    input  logic                     iss_en,
    input  logic [ADDR_W-1:0]        iss_addr
);

    localparam int DEPTH = 1 << ADDR_W;

    rf_state_t         state_q;
    logic [ADDR_W-1:0] clr_cnt_q;
    logic              ready_q;
    logic [DEPTH-1:0]  busy_q;
    logic [DEPTH-1:0]  busy_d;

    logic [DATA_W-1:0] mem [DEPTH];

    logic in_run;
    logic wr0_commit;
    logic wr1_commit;

    assign in_run     = (state_q == ST_RUN);
    assign wr0_commit = in_run && we0 && (!ZERO_R0 || (wa0 != '0));
    assign wr1_commit = in_run && we1 && (!ZERO_R0 || (wa1 != '0));
    assign ready      = ready_q;

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_q   <= ST_CLEAR;
            clr_cnt_q <= '0;
            ready_q   <= 1'b0;
            busy_q    <= '0;
        end else begin
            busy_q <= busy_d;
            case (state_q)
                ST_CLEAR: begin
                    // A clr_req arriving mid-sweep is deliberately not looked at.
                    clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
                    if (&clr_cnt_q) begin
                        state_q <= ST_RUN;
                        ready_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (clr_req) begin
                        state_q   <= ST_CLEAR;
                        clr_cnt_q <= '0;
                        ready_q   <= 1'b0;
                    end
                end
                default: begin
                    state_q   <= ST_CLEAR;
                    clr_cnt_q <= '0;
                    ready_q   <= 1'b0;
                end
            endcase
        end
    end

    // Scoreboard next state: a new issue beats a retiring write to the same entry.
    generate
        for (genvar gi = 0; gi < DEPTH; gi++) begin : g_busy
            logic set_hit;
            logic clr_hit;
            logic sweep_hit;

            assign set_hit   = in_run && iss_en && (iss_addr == ADDR_W'(gi))
                               && !(ZERO_R0 && (gi == 0));
            assign clr_hit   = (wr0_commit && (wa0 == ADDR_W'(gi)))
                               || (wr1_commit && (wa1 == ADDR_W'(gi)));
            assign sweep_hit = !in_run && (clr_cnt_q == ADDR_W'(gi));

            always_comb begin
                busy_d[gi] = busy_q[gi];
                if (sweep_hit) begin
                    busy_d[gi] = 1'b0;
                end else if (set_hit) begin
                    busy_d[gi] = 1'b1;
                end else if (clr_hit) begin
                    busy_d[gi] = 1'b0;
                end
            end
        end
    endgenerate

    // Storage carries no reset; the sweep is what makes its contents defined.
    always_ff @(posedge cpu_clk_50M) begin
        if (!in_run) begin
            mem[clr_cnt_q] <= '0;
        end else begin
            if (wr0_commit) begin
                mem[wa0] <= wd0;
            end
            if (wr1_commit) begin
                mem[wa1] <= wd1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_RD; gi++) begin : g_rd
            logic [ADDR_W-1:0] ra_k;
            logic              en_k;

            assign ra_k = ra[gi*ADDR_W +: ADDR_W];
            assign en_k = re[gi] && ready_q;

            regfile_rdport #(
                .DATA_W  (DATA_W),
                .ADDR_W  (ADDR_W),
                .ZERO_R0 (ZERO_R0)
            ) u_rdport (
                .en_i     (en_k),
                .ra_i     (ra_k),
                .stored_i (mem[ra_k]),
                .wr0_i    (wr0_commit),
                .wa0_i    (wa0),
                .wd0_i    (wd0),
                .wr1_i    (wr1_commit),
                .wa1_i    (wa1),
                .wd1_i    (wd1),
                .rd_o     (rd[gi*DATA_W +: DATA_W])
            );

            assign rd_busy[gi] = en_k && busy_q[ra_k];
        end
    endgenerate

endmodule : regfile_sb

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter DATA_W, 32, register width in bits.
REQ-002 Parameter ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
REQ-003 Parameter NUM_RD, 2, number of read ports (1..4).
REQ-004 Parameter ZERO_R0, 1, entry 0 reads as zero, ignores writes and is never busy.
REQ-005 cpu_clk_50M  in  1  single clock; all state on rising edge.
REQ-006 cpu_rst_n  in  1  reset, asynchronous assert, active-low.
REQ-007 clr_req  in  1  soft request to re-clear all entries and scoreboard.
REQ-008 ready  out  1  high when storage is initialised and ports are live.
REQ-009 we0 / wa0 / wd0  in  1 / ADDR_W / DATA_W  write port 0.
REQ-010 we1 / wa1 / wd1  in  1 / ADDR_W / DATA_W  write port 1; higher priority.
REQ-011 re  in  NUM_RD  per-port read enable.
REQ-012 ra  in  NUM_RD*ADDR_W  flattened read addresses, port k at bits [k*ADDR_W +: ADDR_W].
REQ-013 rd  out  NUM_RD*DATA_W  flattened read data, same packing.
REQ-014 rd_busy  out  NUM_RD  scoreboard busy bit of addressed entry.
REQ-015 iss_en / iss_addr  in  1 / ADDR_W  mark an entry as having a pending producer.

Function
REQ-016 FSM states: CLEAR, RUN; reset enters CLEAR with clear counter = 0.
REQ-017 CLEAR: one entry per cycle written to zero and its busy bit cleared, counter incrementing 0..DEPTH-1.
REQ-018 CLEAR -> RUN in the cycle after entry DEPTH-1 is cleared; clear therefore takes exactly DEPTH cycles, with ready rising on cycle DEPTH+1 after reset release.
REQ-019 RUN -> CLEAR when clr_req=1 is sampled; counter restarts at 0.
REQ-020 clr_req sampled during CLEAR is ignored; the current sweep continues without restarting.
REQ-021 ready = 1 only in RUN.
REQ-022 In CLEAR, all writes and issues are ignored, every rd = 0 and every rd_busy = 0.
REQ-023 Writes commit at the rising edge when weX=1 and (ZERO_R0=0 or waX!=0).
REQ-024 If we0 and we1 target the same address in one cycle, wd1 is stored.
REQ-025 Reads are combinational with zero latency.
REQ-026 Read port k returns 0 when re[k]=0, or when ZERO_R0=1 and ra=0.
REQ-027 Otherwise, read port k forwards wd1 if we1 hits ra, else wd0 if we0 hits ra, else the stored value.
REQ-028 Busy bit set at edge when iss_en=1 (except entry 0 if ZERO_R0).
REQ-029 Busy bit cleared at edge by any committing write to that entry.
REQ-030 When a set and a clear hit the same entry in the same cycle, set wins.
REQ-031 rd_busy[k] reflects the registered busy bit only; it is not bypassed by same-cycle writes or issues.
REQ-032 rd_busy[k] = 0 when re[k]=0.

Reset
REQ-033 cpu_rst_n=0 asynchronously forces: state=CLEAR, counter=0, ready=0, all busy bits=0.
REQ-034 Data array has no reset; it is initialised only by the CLEAR sweep.
REQ-035 Reset asserted mid-sweep or mid-RUN restarts a full sweep after release.
REQ-036 rd=0 whenever cpu_rst_n=0.

Structure
REQ-037 Shared package holds the FSM state encoding, default parameter values and the zero-word constant.
REQ-038 One sub-module regfile_rdport (single read port: enable, zero-reg check, two-level forwarding mux) is instantiated NUM_RD times by generate.

Verification
REQ-039 Release reset with DEPTH=32: ready=0 for 32 cycles, then ready=1; reading any entry then returns 0x00000000.
REQ-040 we0 wa0=3 wd0=0x11111111 and we1 wa1=3 wd1=0x22222222 in the same cycle: same-cycle read of ra=3 gives 0x22222222, and the next cycle also returns 0x22222222.
REQ-041 we0 wa0=0 wd0=0xDEADBEEF with ZERO_R0=1: read of ra=0 gives 0 in the same cycle and afterwards; rd_busy stays 0 after iss_en on address 0.
REQ-042 iss_en on address 7, then 3 cycles later we0 wa0=7: rd_busy=1 for 3 cycles and 0 after the write edge.
REQ-043 Same-cycle iss_en and write to address 7: rd_busy=1 afterwards.
REQ-044 Write 0x5 to address 9, then clr_req: ready=0 for 32 cycles, writes during that window are ignored, and address 9 reads 0 after ready returns.
REQ-045 Assert reset mid-sweep at counter=10: the sweep restarts from 0 after release and ready rises after 32 cycles.
